// File: rtl/uart_frame_driver.sv
// UART stimulus source: a byte FIFO feeding a registered serialiser with
// configurable framing (data bits, parity, stop bits, inter-frame gap),
// ENABLE flow gating, a sticky overflow flag and a wrapping frame counter.
module uart_frame_driver #(
    parameter int CLK_DIV   = 868,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int GAP_BITS  = 0,
    parameter int DEPTH     = 16
) (
    input  logic                 SYSCLK,
    input  logic                 NSYSRESET,
    input  logic                 WR_EN,
    input  logic [DATA_BITS-1:0] WR_DATA,
    input  logic                 ENABLE,
    output logic                 TX_OUT,
    output logic                 FULL,
    output logic                 EMPTY,
    output logic                 BUSY,
    output logic                 FRAME_DONE,
    output logic                 OVERFLOW,
    output logic [15:0]          SENT_CNT
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} state_t;

    logic [1:0]           rst_sync_q, rst_sync_d;
    logic                 rst_n;
    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] head;
    logic                 push, pop, full, empty, tick, frame_end;
    logic                 ovf_q, ovf_d;
    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic [15:0]          sent_cnt_q, sent_cnt_d;

    // Reset synchroniser: assertion is immediate, release waits two edges.
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    // Reset synchroniser register.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) rst_sync_q <= '0;
        else            rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    // FIFO status; pointers carry one extra wrap bit to split full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = WR_EN && !full;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign tick  = (timer_q == '0);

    // FIFO pointer advance and sticky overflow (a same-cycle pop does not excuse it).
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        ovf_d    = ovf_q | (WR_EN & full);
    end

    // FIFO storage; no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge SYSCLK) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= WR_DATA;
    end

    // Frame sequencer: per-bit timer, bit counter, pop/load and registered line value.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        sent_cnt_d = sent_cnt_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        frame_end  = 1'b0;
        tx_d       = 1'b1;

        if (state_q != IDLE) timer_d = tick ? TW'(CLK_DIV - 1) : timer_q - 1'b1;

        case (state_q)
            IDLE: ;
            START: if (tick) begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA: if (tick) begin
                shift_d = shift_q >> 1;
                if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                    bit_cnt_d = '0;
                    state_d   = (PARITY != 0) ? PAR : STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            PAR: if (tick) begin
                state_d   = STOP;
                bit_cnt_d = '0;
            end
            STOP: if (tick) begin
                if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                    bit_cnt_d = '0;
                    if (GAP_BITS != 0) state_d = GAP;
                    else               frame_end = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            GAP: if (tick) begin
                if (bit_cnt_q == 4'(GAP_BITS - 1)) frame_end = 1'b1;
                else                               bit_cnt_d = bit_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (frame_end) begin
            done_d     = 1'b1;
            sent_cnt_d = sent_cnt_q + 16'd1;
            state_d    = IDLE;
        end

        // Load the next byte from IDLE, or straight from frame end for back-to-back frames.
        if ((state_q == IDLE || frame_end) && ENABLE && !empty) begin
            pop       = 1'b1;
            shift_d   = head;
            par_d     = (PARITY == 2) ? ^head : ~^head;
            state_d   = START;
            timer_d   = TW'(CLK_DIV - 1);
            bit_cnt_d = '0;
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PAR:     tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    // State registers; reset truncates any frame in flight and idles the line.
    always_ff @(posedge SYSCLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            state_q    <= IDLE;
            timer_q    <= TW'(CLK_DIV - 1);
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            sent_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            sent_cnt_q <= sent_cnt_d;
        end
    end

    assign TX_OUT     = tx_q;
    assign FULL       = full;
    assign EMPTY      = empty;
    assign BUSY       = (state_q != IDLE);
    assign FRAME_DONE = done_q;
    assign OVERFLOW   = ovf_q;
    assign SENT_CNT   = sent_cnt_q;

endmodule

// File: tb/tb_uart_frame_driver.sv
// Bench for uart_frame_driver: three instances (8N1 depth 4, 8E2, 8O1 with a
// 3-bit gap), a per-instance serial monitor checking frames against queued
// expectations, plus directed latency/flag checks.
module tb_uart_frame_driver;
    typedef struct {
        logic [7:0] d;
        int         par;   // expected parity bit, -1 when the frame has none
        int         gap;   // expected idle-high cycles after previous stop, -1 = don't care
    } exp_t;

    logic              clk, rstn;
    logic [2:0]        wr_en, en;
    logic [7:0]        wr_d [3];
    wire  [2:0]        tx_w, full_w, empty_w, busy_w, done_w, ovf_w;
    wire  [2:0][15:0]  cnt_w;
    exp_t              sbq [3][$];
    int                n_tests, n_fail;

    uart_frame_driver #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .GAP_BITS(0), .DEPTH(4)) u_a (
        .SYSCLK(clk), .NSYSRESET(rstn), .WR_EN(wr_en[0]), .WR_DATA(wr_d[0]), .ENABLE(en[0]),
        .TX_OUT(tx_w[0]), .FULL(full_w[0]), .EMPTY(empty_w[0]), .BUSY(busy_w[0]),
        .FRAME_DONE(done_w[0]), .OVERFLOW(ovf_w[0]), .SENT_CNT(cnt_w[0]));

    uart_frame_driver #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .GAP_BITS(0), .DEPTH(4)) u_b (
        .SYSCLK(clk), .NSYSRESET(rstn), .WR_EN(wr_en[1]), .WR_DATA(wr_d[1]), .ENABLE(en[1]),
        .TX_OUT(tx_w[1]), .FULL(full_w[1]), .EMPTY(empty_w[1]), .BUSY(busy_w[1]),
        .FRAME_DONE(done_w[1]), .OVERFLOW(ovf_w[1]), .SENT_CNT(cnt_w[1]));

    uart_frame_driver #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .GAP_BITS(3), .DEPTH(16)) u_c (
        .SYSCLK(clk), .NSYSRESET(rstn), .WR_EN(wr_en[2]), .WR_DATA(wr_d[2]), .ENABLE(en[2]),
        .TX_OUT(tx_w[2]), .FULL(full_w[2]), .EMPTY(empty_w[2]), .BUSY(busy_w[2]),
        .FRAME_DONE(done_w[2]), .OVERFLOW(ovf_w[2]), .SENT_CNT(cnt_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bit period of n cycles: value of the first sample, stability, reset seen.
    task automatic per_full(input int idx, input int n, output logic v, output bit st, output bit ab);
        @(negedge clk);
        v  = tx_w[idx];
        ab = (rstn !== 1'b1);
        st = 1'b1;
        repeat (n - 1) begin
            @(negedge clk);
            if (rstn !== 1'b1) ab = 1'b1;
            if (tx_w[idx] !== v) st = 1'b0;
        end
    endtask

    // Serial monitor: decode each frame on tx_w[idx] and compare with the scoreboard.
    task automatic mon(input int idx, input bit has_par, input int sb);
        int hi;
        exp_t e;
        logic v, pv;
        bit st, ab, dead, st_ok;
        logic [7:0] d;
        hi = 0;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_w[idx] !== 1'b0) begin
                hi++;
                continue;
            end
            if (sbq[idx].size() == 0) begin
                chk($sformatf("u%0d_unexpected_frame", idx), 0, 1);
                e = '{8'h00, -1, -1};
            end else begin
                e = sbq[idx].pop_front();
            end
            if (e.gap >= 0) chk($sformatf("u%0d_gap_%0h", idx, e.d), hi, e.gap);
            dead  = 1'b0;
            st_ok = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (rstn !== 1'b1) dead = 1'b1;
                if (tx_w[idx] !== 1'b0) st_ok = 1'b0;
            end
            for (int i = 0; i < 8 && !dead; i++) begin
                per_full(idx, 4, v, st, ab);
                dead |= ab;
                d[i] = v;
                st_ok &= st;
            end
            if (has_par && !dead) begin
                per_full(idx, 4, pv, st, ab);
                dead |= ab;
                st_ok &= st;
            end
            if (!dead) begin
                per_full(idx, 4 * sb, v, st, ab);
                dead |= ab;
                st_ok &= st;
            end
            if (!dead) begin
                chk($sformatf("u%0d_data", idx), d, e.d);
                chk($sformatf("u%0d_bit_timing_%0h", idx, e.d), st_ok, 1);
                chk($sformatf("u%0d_stop_%0h", idx, e.d), v, 1);
                if (has_par) chk($sformatf("u%0d_parity_%0h", idx, e.d), pv, e.par);
            end
            hi = 0;
        end
    endtask

    task automatic wr(input int idx, input logic [7:0] b);
        wr_en[idx] = 1'b1;
        wr_d[idx]  = b;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        n_tests = 0;
        n_fail  = 0;
        rstn  = 1'b0;
        wr_en = '0;
        en    = 3'b111;
        for (int i = 0; i < 3; i++) wr_d[i] = 8'h00;
        fork
            mon(0, 1'b0, 1);
            mon(1, 1'b1, 2);
            mon(2, 1'b1, 1);
        join_none

        // Reset state
        cyc(3);
        chk("rst_tx", tx_w[0], 1);
        chk("rst_full", full_w[0], 0);
        chk("rst_empty", empty_w[0], 1);
        chk("rst_busy", busy_w[0], 0);
        chk("rst_done", done_w[0], 0);
        chk("rst_ovf", ovf_w[0], 0);
        chk("rst_cnt", cnt_w[0], 0);
        rstn = 1'b1;
        cyc(5);

        // Single 8N1 frame of 0x55: start two cycles after the write
        wr(0, 8'h55); sbq[0].push_back('{8'h55, -1, -1});
        cyc(1); wr_en[0] = 1'b0;
        chk("t1_tx_before_start", tx_w[0], 1);
        chk("t1_not_empty", empty_w[0], 0);
        cyc(1);
        chk("t1_start_latency", tx_w[0], 0);
        chk("t1_busy", busy_w[0], 1);
        cyc(40);
        chk("t1_frame_done", done_w[0], 1);
        chk("t1_sent_cnt", cnt_w[0], 1);
        chk("t1_idle_busy", busy_w[0], 0);
        cyc(1);
        chk("t1_done_pulse", done_w[0], 0);
        cyc(5);

        // ENABLE dropped during data bit 3: frame completes, next byte held
        wr(0, 8'h3C); sbq[0].push_back('{8'h3C, -1, -1});
        cyc(1); wr(0, 8'h81); sbq[0].push_back('{8'h81, -1, -1});
        cyc(1); wr_en[0] = 1'b0;
        chk("t6_start", tx_w[0], 0);
        cyc(17); en[0] = 1'b0;
        cyc(23);
        chk("t6_done", done_w[0], 1);
        chk("t6_cnt", cnt_w[0], 2);
        chk("t6_held_busy", busy_w[0], 0);
        chk("t6_held_not_empty", empty_w[0], 0);
        cyc(6);
        chk("t6_held_line", tx_w[0], 1);
        en[0] = 1'b1;
        cyc(1);
        chk("t6_restart_1cyc", tx_w[0], 0);
        cyc(40);
        chk("t6_cnt2", cnt_w[0], 3);
        cyc(3);

        // Overflow: depth 4, six writes while disabled, then drain back-to-back
        en[0] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wr(0, 8'(i));
            sbq[0].push_back('{8'(i), -1, (i == 1) ? -1 : 0});
            cyc(1);
        end
        chk("t3_full", full_w[0], 1);
        chk("t3_no_ovf_yet", ovf_w[0], 0);
        wr(0, 8'h05); cyc(1);
        wr(0, 8'h06); cyc(1);
        wr_en[0] = 1'b0;
        chk("t3_ovf", ovf_w[0], 1);
        chk("t3_still_full", full_w[0], 1);
        en[0] = 1'b1;
        cyc(170);
        chk("t3_empty", empty_w[0], 1);
        chk("t3_busy", busy_w[0], 0);
        chk("t3_cnt", cnt_w[0], 7);
        chk("t3_ovf_sticky", ovf_w[0], 1);

        // Reset mid-data of 0xA3 with another byte queued
        wr(0, 8'hA3); sbq[0].push_back('{8'hA3, -1, -1});
        cyc(1); wr(0, 8'h11);
        cyc(1); wr_en[0] = 1'b0;
        cyc(10);
        rstn = 1'b0;
        #1;
        chk("t5_tx_high", tx_w[0], 1);
        chk("t5_empty", empty_w[0], 1);
        chk("t5_cnt", cnt_w[0], 0);
        chk("t5_busy", busy_w[0], 0);
        chk("t5_ovf_clr", ovf_w[0], 0);
        cyc(2);
        rstn = 1'b1;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1) lows++;
        end
        chk("t5_no_frame_after_rst", lows, 0);
        chk("t5_idle_busy", busy_w[0], 0);

        // Parity (even on u_b, odd on u_c), two stop bits, 3-bit gap
        wr(1, 8'h07); sbq[1].push_back('{8'h07, 1, -1});
        wr(2, 8'h07); sbq[2].push_back('{8'h07, 0, -1});
        cyc(1);
        wr(1, 8'h03); sbq[1].push_back('{8'h03, 0, 0});
        wr(2, 8'h03); sbq[2].push_back('{8'h03, 1, 12});
        cyc(1);
        wr_en = '0;
        cyc(140);
        chk("u_b_cnt", cnt_w[1], 2);
        chk("u_c_cnt", cnt_w[2], 2);
        chk("u_b_idle", busy_w[1], 0);
        chk("u_c_idle", busy_w[2], 0);

        for (int i = 0; i < 3; i++) chk($sformatf("u%0d_scoreboard_drained", i), sbq[i].size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
